rr_arb4_ctrl: RTL and testbench

- Round-robin arbiter that shares one 4-way resource between four requesters.
- Winner is held as a 2-bit index; a 2-to-4 one-hot decoder stage drives the per-requester grant lines.
- A hold counter bounds tenure so that no requester can starve the others.
- Sits between the requester blocks and the shared resource's select/enable lines.

---
 rtl/rr_arb4_ctrl_pkg.sv | 23 ++
 rtl/rr_arb4_ctrl_dec.sv | 31 +++
 rtl/rr_arb4_ctrl.sv | 133 +++++++++++++
 tb/tb_rr_arb4_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb4_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// rr_arb4_ctrl_pkg
//
// Purpose:
//   Shared definitions for the four-way round-robin arbiter: requester count,
//   owner index width and the arbiter state encoding.
//
// Contents:
//   NUM_REQ  - number of requesters sharing the resource
//   IDX_W    - width of a requester index
//   state_t  - arbiter state (ST_IDLE, ST_GRANT)
// ----------------------------------------------------------------------------
package rr_arb4_ctrl_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage : rr_arb4_ctrl_pkg

// File: rtl/rr_arb4_ctrl_dec.sv
// ----------------------------------------------------------------------------
// de2to4_dec
//
// Purpose:
//   Purely combinational 2-bit to 4-bit one-hot decoder. The arbiter feeds it
//   the index of the next owner, and the arbiter registers the result into
//   its grant lines.
//
// Ports:
//   idx     in   2  binary index
//   onehot  out  4  one-hot decode of idx (00->0001 ... 11->1000)
// ----------------------------------------------------------------------------
module de2to4_dec
    import rr_arb4_ctrl_pkg::*;
(
    input  logic [IDX_W-1:0]   idx,
    output logic [NUM_REQ-1:0] onehot
);

    always_comb begin
        onehot = '0;
        case (idx)
            2'd0:    onehot = 4'b0001;
            2'd1:    onehot = 4'b0010;
            2'd2:    onehot = 4'b0100;
            2'd3:    onehot = 4'b1000;
            default: onehot = '0;
        endcase
    end

endmodule : de2to4_dec

// File: rtl/rr_arb4_ctrl.sv
// ----------------------------------------------------------------------------
// rr_arb4_ctrl
//
// Purpose:
//   Round-robin arbiter sharing one resource among four requesters. A grant
//   is held while its owner keeps requesting, but a hold counter bounds the
//   tenure whenever anyone else is waiting, so no requester can starve the
//   others. Every output is registered.
//
// Parameters:
//   MAX_HOLD  max cycles a grant is held while others wait (1..2^HOLD_W-1)
//   HOLD_W    hold counter width
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous active-high reset
//   req        in   4  request vector, bit i = requester i
//   gnt        out  4  one-hot grant, zero when idle
//   gnt_idx    out  2  index of current owner, meaningful while gnt_valid=1
//   gnt_valid  out  1  high while a grant is held
//   preempt    out  1  one-cycle pulse when a grant is revoked by timeout
// ----------------------------------------------------------------------------
module rr_arb4_ctrl
    import rr_arb4_ctrl_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               preempt
);

    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

    state_t               state;
    logic [IDX_W-1:0]     ptr;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [IDX_W-1:0]     winner;
    logic [NUM_REQ-1:0]   winner_onehot;
    logic                 owner_req;
    logic                 others_req;

    // First requester found when scanning ptr, ptr+1, ... (mod 4). Index
    // arithmetic wraps naturally in IDX_W bits. Only meaningful when r != 0.
    function automatic logic [IDX_W-1:0] rr_search(
        input logic [NUM_REQ-1:0] r,
        input logic [IDX_W-1:0]   p
    );
        logic [IDX_W-1:0] cand;
        logic             found;
        rr_search = p;
        found     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = p + IDX_W'(i);
            if (!found && r[cand]) begin
                rr_search = cand;
                found     = 1'b1;
            end
        end
    endfunction

    assign winner = rr_search(req, ptr);

    de2to4_dec u_dec (
        .idx    (winner),
        .onehot (winner_onehot)
    );

    // In GRANT, gnt is the owner's one-hot, so masking it out of req leaves
    // exactly the competitors.
    assign owner_req  = req[gnt_idx];
    assign others_req = |(req & ~gnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    preempt <= 1'b0;
                    if (|req) begin
                        gnt       <= winner_onehot;
                        gnt_idx   <= winner;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= HOLD_W'(1);
                        // The new owner drops to lowest priority next time.
                        ptr       <= winner + IDX_W'(1);
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!owner_req) begin
                        // Voluntary release wins over a coincident timeout.
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        preempt   <= 1'b0;
                        hold_cnt  <= '0;
                        state     <= ST_IDLE;
                    end else if (hold_cnt == HOLD_LIMIT && others_req) begin
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        preempt   <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= ST_IDLE;
                    end else begin
                        // A lone owner may keep the grant forever; the
                        // counter saturates so a late competitor still
                        // sees an expired tenure.
                        preempt <= 1'b0;
                        if (hold_cnt != HOLD_LIMIT) begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : rr_arb4_ctrl

// File: tb/tb_rr_arb4_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rr_arb4_ctrl
//
// Purpose:
//   Self-checking bench for rr_arb4_ctrl. Directed scenarios check against
//   fixed expected values; the random scenario checks against a behavioural
//   model that tracks the owner as an integer and applies the arbitration
//   rules directly.
// ----------------------------------------------------------------------------
module tb_rr_arb4_ctrl;

    localparam int MAX_HOLD   = 8;
    localparam int HOLD_W     = 4;
    localparam int WAIT_LIMIT = 4 * (MAX_HOLD + 1);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: owner is -1 when idle.
    int   m_owner   = -1;
    int   m_held    = 0;
    int   m_first   = 0;
    logic m_preempt = 1'b0;

    always #5 clk = ~clk;

    rr_arb4_ctrl #(
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (HOLD_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    function automatic logic [3:0] model_gnt();
        if (m_owner < 0) return 4'b0000;
        return 4'(4'b0001 << m_owner);
    endfunction

    // Apply one clock edge's worth of arbitration rules to the model.
    task automatic model_step(input logic [3:0] r, input logic rs);
        int  c;
        bit  found;
        if (rs) begin
            m_owner   = -1;
            m_held    = 0;
            m_first   = 0;
            m_preempt = 1'b0;
        end else if (m_owner < 0) begin
            m_preempt = 1'b0;
            found     = 1'b0;
            for (int k = 0; k < 4; k++) begin
                c = (m_first + k) % 4;
                if (!found && r[c]) begin
                    found   = 1'b1;
                    m_owner = c;
                    m_held  = 1;
                    m_first = (c + 1) % 4;
                end
            end
        end else if (!r[m_owner]) begin
            m_owner   = -1;
            m_preempt = 1'b0;
        end else if (m_held >= MAX_HOLD && (r & ~(4'b0001 << m_owner)) != 4'b0000) begin
            m_owner   = -1;
            m_preempt = 1'b1;
        end else begin
            m_held    = m_held + 1;
            m_preempt = 1'b0;
        end
    endtask

    // Drive one cycle: inputs set at the falling edge, model advanced at the
    // rising edge, and control returns at the next falling edge for sampling.
    task automatic step(input logic [3:0] r, input logic rs);
        req = r;
        rst = rs;
        @(posedge clk);
        model_step(r, rs);
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        do_reset();
        vectors++;
        if ({gnt, gnt_idx, gnt_valid, preempt} !== 8'b0000_00_0_0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got gnt=%b idx=%0d valid=%b preempt=%b, expected 0000/0/0/0",
                     gnt, gnt_idx, gnt_valid, preempt);
        end
        for (int i = 0; i < 3; i++) step(4'b0100, 1'b0);
        vectors++;
        if (gnt !== 4'b0100) begin
            miscompares++;
            $display("[TB] FAIL reset_pregrant: got %b expected 0100", gnt);
        end
        step(4'b0100, 1'b1);
        vectors++;
        if ({gnt, gnt_valid, preempt} !== 6'b0000_0_0) begin
            miscompares++;
            $display("[TB] FAIL reset_midgrant: got gnt=%b valid=%b preempt=%b, expected 0000/0/0",
                     gnt, gnt_valid, preempt);
        end
        step(4'b1010, 1'b0);
        vectors++;
        if ({gnt, gnt_idx} !== 6'b0010_01) begin
            miscompares++;
            $display("[TB] FAIL reset_firstreq: got gnt=%b idx=%0d expected 0010/1", gnt, gnt_idx);
        end
    endtask

    task automatic test_single();
        $display("[TB] test_single");
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(4'b0100, 1'b0);
            vectors++;
            if ({gnt, gnt_idx, gnt_valid, preempt} !== 8'b0100_10_1_0) begin
                miscompares++;
                $display("[TB] FAIL single_hold[%0d]: got gnt=%b idx=%0d valid=%b preempt=%b, expected 0100/2/1/0",
                         i, gnt, gnt_idx, gnt_valid, preempt);
            end
        end
        step(4'b0000, 1'b0);
        vectors++;
        if ({gnt, gnt_valid} !== 5'b0000_0) begin
            miscompares++;
            $display("[TB] FAIL single_release: got gnt=%b valid=%b expected 0000/0", gnt, gnt_valid);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] rq [9];
        logic [3:0] eg [9];
        $display("[TB] test_rotation");
        rq = '{4'b1111, 4'b1110, 4'b1111, 4'b1101, 4'b1111, 4'b1011, 4'b1111, 4'b0111, 4'b1111};
        eg = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(rq[i], 1'b0);
            vectors++;
            if (gnt !== eg[i] || preempt !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL rotation[%0d]: got gnt=%b preempt=%b expected %b/0",
                         i, gnt, preempt, eg[i]);
            end
        end
    endtask

    task automatic test_preempt();
        logic [3:0] eg;
        logic       ep;
        $display("[TB] test_preempt");
        do_reset();
        for (int i = 1; i <= 2 * MAX_HOLD + 3; i++) begin
            step(4'b0011, 1'b0);
            if (i <= MAX_HOLD) begin
                eg = 4'b0001; ep = 1'b0;
            end else if (i == MAX_HOLD + 1) begin
                eg = 4'b0000; ep = 1'b1;
            end else if (i <= 2 * MAX_HOLD + 1) begin
                eg = 4'b0010; ep = 1'b0;
            end else if (i == 2 * MAX_HOLD + 2) begin
                eg = 4'b0000; ep = 1'b1;
            end else begin
                eg = 4'b0001; ep = 1'b0;
            end
            vectors++;
            if (gnt !== eg || preempt !== ep) begin
                miscompares++;
                $display("[TB] FAIL preempt_cycle[%0d]: got gnt=%b preempt=%b expected %b/%b",
                         i, gnt, preempt, eg, ep);
            end
        end
    endtask

    task automatic test_simultaneous();
        $display("[TB] test_simultaneous");
        do_reset();
        for (int i = 0; i < MAX_HOLD; i++) step(4'b0011, 1'b0);
        vectors++;
        if (gnt !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL simul_owner: got %b expected 0001", gnt);
        end
        step(4'b0010, 1'b0);
        vectors++;
        if ({gnt, preempt} !== 5'b0000_0) begin
            miscompares++;
            $display("[TB] FAIL simul_release: got gnt=%b preempt=%b expected 0000/0", gnt, preempt);
        end
        step(4'b0010, 1'b0);
        vectors++;
        if (gnt !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL simul_next: got %b expected 0010", gnt);
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic       rs;
        logic [3:0] eg;
        int         waits [4];
        $display("[TB] test_random");
        do_reset();
        r = 4'b0000;
        for (int k = 0; k < 4; k++) waits[k] = 0;
        for (int n = 0; n < 10000; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
            end
            rs = ($urandom_range(0, 999) == 0);
            step(r, rs);
            eg = model_gnt();
            vectors++;
            if (gnt !== eg || gnt_valid !== (m_owner >= 0) || preempt !== m_preempt) begin
                miscompares++;
                $display("[TB] FAIL random_out[%0d]: got gnt=%b valid=%b preempt=%b expected %b/%b/%b",
                         n, gnt, gnt_valid, preempt, eg, (m_owner >= 0), m_preempt);
            end
            vectors++;
            if ((gnt & (gnt - 4'b0001)) !== 4'b0000 || gnt_valid !== |gnt ||
                (gnt_valid === 1'b1 && gnt !== 4'(4'b0001 << gnt_idx))) begin
                miscompares++;
                $display("[TB] FAIL random_invariant[%0d]: got gnt=%b idx=%0d valid=%b",
                         n, gnt, gnt_idx, gnt_valid);
            end
            if (m_owner >= 0) begin
                vectors++;
                if (gnt_idx !== 2'(m_owner)) begin
                    miscompares++;
                    $display("[TB] FAIL random_idx[%0d]: got %0d expected %0d", n, gnt_idx, m_owner);
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (rs || !r[k] || gnt[k]) waits[k] = 0;
                else waits[k] = waits[k] + 1;
                if (waits[k] > WAIT_LIMIT) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL random_starve[%0d]: requester %0d waited %0d cycles, limit %0d",
                             n, k, waits[k], WAIT_LIMIT);
                    waits[k] = 0;
                end
            end
        end
        vectors++;
        if (waits[0] > WAIT_LIMIT || waits[1] > WAIT_LIMIT || waits[2] > WAIT_LIMIT || waits[3] > WAIT_LIMIT) begin
            miscompares++;
            $display("[TB] FAIL random_final_wait: wait counts exceed %0d", WAIT_LIMIT);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_rotation();
        test_preempt();
        test_simultaneous();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_rr_arb4_ctrl
